// File: rtl/scrambler_par_if.sv
// Streaming beat interface used on both sides of scrambler_par:
// valid/ready handshake with a start-of-frame marker and a data beat.
interface scrambler_par_if #(
  parameter int DATA_W = 8
);
  logic              valid;
  logic              ready;
  logic              sof;
  logic [DATA_W-1:0] data;

  // Producer of beats
  modport master (
    output valid,
    output sof,
    output data,
    input  ready
  );

  // Consumer of beats
  modport slave (
    input  valid,
    input  sof,
    input  data,
    output ready
  );
endinterface

// File: rtl/scrambler_par.sv
// scrambler_par: 802.11 additive scrambler / descrambler, DATA_W bits per beat,
// bit0 of each beat is earliest in time. Polynomial x^7 + x^4 + 1.
// mode 0 (TX) seeds the LFSR from seed_in on the sof beat; mode 1 (RX) loads the
// LFSR from the first LFSR_W received bits of the frame (SERVICE field), forcing
// those output bits to zero, then descrambles the rest of the frame.
// Optional feature: define SCRAMBLER_STATE_OUT_EN to expose the LFSR state on
// port state_out.
module scrambler_par #(
  parameter int                DATA_W   = 8,
  parameter int                LFSR_W   = 7,
  parameter logic [LFSR_W-1:0] SEED_DEF = 7'h7F
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mode,
  input  logic [LFSR_W-1:0] seed_in,
  scrambler_par_if.slave    upstream,
  scrambler_par_if.master   downstream,
  output logic              synced
`ifdef SCRAMBLER_STATE_OUT_EN
  ,
  output logic [LFSR_W-1:0] state_out
`endif
);

  localparam int                CNT_W     = $clog2(LFSR_W + 1);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0]  SYNC_BITS = CNT_W'(LFSR_W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SYNC = 2'd1,
    RUN  = 2'd2
  } fsm_t;

  fsm_t              fsm;
  logic [LFSR_W-1:0] lfsr;
  logic [CNT_W-1:0]  bit_cnt;
  logic              obuf_valid;
  logic              obuf_sof;
  logic [DATA_W-1:0] obuf_data;

  fsm_t              nxt_fsm;
  logic [LFSR_W-1:0] nxt_lfsr;
  logic [CNT_W-1:0]  nxt_cnt;
  logic [DATA_W-1:0] nxt_data;
  logic              emit;
  logic              accept;
  logic              fb;

  // A new beat can enter whenever the single output register is empty or draining.
  assign upstream.ready  = !obuf_valid || downstream.ready;
  assign accept          = upstream.valid && upstream.ready;
  assign downstream.valid = obuf_valid;
  assign downstream.sof   = obuf_sof;
  assign downstream.data  = obuf_data;

`ifdef SCRAMBLER_STATE_OUT_EN
  assign state_out = lfsr;
`endif

  // Process one beat bit-serially: sof seeding/restart, then SYNC or RUN per bit.
  always_comb begin
    nxt_fsm  = fsm;
    nxt_lfsr = lfsr;
    nxt_cnt  = bit_cnt;
    nxt_data = '0;
    emit     = 1'b0;
    fb       = 1'b0;
    if (upstream.sof) begin
      emit = 1'b1;
      if (mode == 1'b0) begin
        nxt_fsm  = RUN;
        nxt_lfsr = (seed_in == '0) ? SEED_DEF : seed_in;
      end else begin
        nxt_fsm = SYNC;
        nxt_cnt = '0;
      end
    end else if (fsm == IDLE) begin
      // Beats outside a frame are swallowed without touching state.
      emit = 1'b0;
    end else begin
      emit = 1'b1;
    end
    for (int i = 0; i < DATA_W; i++) begin
      case (nxt_fsm)
        SYNC: begin
          // Received bit equals the keystream here, so it becomes the state.
          nxt_lfsr    = {nxt_lfsr[LFSR_W-2:0], upstream.data[i]};
          nxt_data[i] = 1'b0;
          nxt_cnt     = nxt_cnt + CNT_ONE;
          if (nxt_cnt == SYNC_BITS) begin
            nxt_fsm = RUN;
          end else begin
            nxt_fsm = SYNC;
          end
        end
        RUN: begin
          fb          = nxt_lfsr[LFSR_W-1] ^ nxt_lfsr[3];
          nxt_data[i] = upstream.data[i] ^ fb;
          nxt_lfsr    = {nxt_lfsr[LFSR_W-2:0], fb};
        end
        default: begin
          nxt_data[i] = 1'b0;
        end
      endcase
    end
  end

  // Frame FSM, LFSR state and the registered output stage.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fsm        <= IDLE;
      lfsr       <= SEED_DEF;
      bit_cnt    <= '0;
      synced     <= 1'b0;
      obuf_valid <= 1'b0;
      obuf_sof   <= 1'b0;
      obuf_data  <= '0;
    end else begin
      if (accept) begin
        fsm     <= nxt_fsm;
        lfsr    <= nxt_lfsr;
        bit_cnt <= nxt_cnt;
        synced  <= (nxt_fsm == RUN);
      end
      if (accept && emit) begin
        obuf_valid <= 1'b1;
        obuf_sof   <= upstream.sof;
        obuf_data  <= nxt_data;
      end else if (downstream.ready) begin
        obuf_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_scrambler_par.sv
// Self-checking bench for scrambler_par. The reference model keeps the frame's
// keystream as a bit history and extends it with k[n] = k[n-7] ^ k[n-4];
// TX prefixes the history with the seed bits, RX with the first received bits.
module tb_scrambler_par;
  localparam int DATA_W = 8;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mode = 1'b0;
  logic [6:0] seed_in = 7'h00;
  logic       synced;
`ifdef SCRAMBLER_STATE_OUT_EN
  logic [6:0] state_out;
`endif

  scrambler_par_if #(.DATA_W(DATA_W)) up_bus ();
  scrambler_par_if #(.DATA_W(DATA_W)) dn_bus ();

  always #5 clock = ~clock;

  scrambler_par #(.DATA_W(DATA_W)) dut (
    .clock      (clock),
    .reset      (reset),
    .mode       (mode),
    .seed_in    (seed_in),
    .upstream   (up_bus),
    .downstream (dn_bus),
    .synced     (synced)
`ifdef SCRAMBLER_STATE_OUT_EN
    ,
    .state_out  (state_out)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  bit              m_active = 1'b0;
  bit              m_mode   = 1'b0;
  bit              m_synced = 1'b0;
  bit              hist[$];
  logic [DATA_W:0] exp_q[$];
  bit              cap_on = 1'b0;
  bit              cap_bits[$];
  bit              frame_bits[$];
  bit              tx_bits[$];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_beat(input bit sof, input logic [DATA_W-1:0] d, input bit md, input logic [6:0] sd);
    logic [6:0]        s;
    logic [DATA_W-1:0] ob;
    bit                k;
    if (sof) begin
      m_active = 1'b1;
      m_mode   = md;
      hist.delete();
      if (!md) begin
        s = (sd == 7'h00) ? 7'h7F : sd;
        for (int j = 6; j >= 0; j--) hist.push_back(s[j]);
      end
    end else if (!m_active) begin
      return;
    end
    ob = '0;
    for (int i = 0; i < DATA_W; i++) begin
      if (m_mode && hist.size() < 7) begin
        hist.push_back(d[i]);
        ob[i] = 1'b0;
      end else begin
        k = hist[hist.size()-7] ^ hist[hist.size()-4];
        ob[i] = d[i] ^ k;
        hist.push_back(k);
      end
    end
    while (hist.size() > 16) void'(hist.pop_front());
    exp_q.push_back({sof, ob});
    m_synced = !m_mode || (hist.size() >= 7);
  endtask

  // One clock: drive at negedge, check/model before posedge, check synced after.
  task automatic cycle(input bit v, input bit sof, input logic [DATA_W-1:0] d,
                       input bit md, input logic [6:0] sd, input bit rdy, output bit acc);
    bit              exp_rdy;
    logic [DATA_W:0] e;
    logic [6:0]      st;
    up_bus.valid = v;
    up_bus.sof   = sof;
    up_bus.data  = d;
    mode         = md;
    seed_in      = sd;
    dn_bus.ready = rdy;
    #1;
    check_val("out_valid", dn_bus.valid, exp_q.size() != 0);
    exp_rdy = (exp_q.size() == 0) || rdy;
    check_val("in_ready", up_bus.ready, exp_rdy);
    if (exp_q.size() != 0) begin
      e = exp_q[0];
      check_val("out_sof", dn_bus.sof, e[DATA_W]);
      check_val("out_data", dn_bus.data, e[DATA_W-1:0]);
      if (rdy) begin
        void'(exp_q.pop_front());
        if (cap_on) for (int i = 0; i < DATA_W; i++) cap_bits.push_back(dn_bus.data[i]);
      end
    end
    acc = v && exp_rdy;
    if (acc) model_beat(sof, d, md, sd);
    @(posedge clock);
    @(negedge clock);
    check_val("synced", synced, m_synced);
`ifdef SCRAMBLER_STATE_OUT_EN
    if (m_active && hist.size() >= 7) begin
      for (int j = 0; j < 7; j++) st[j] = hist[hist.size()-1-j];
      check_val("state_out", state_out, st);
    end
`endif
  endtask

  task automatic do_reset();
    reset = 1'b1;
    up_bus.valid = 1'b0;
    up_bus.sof   = 1'b0;
    up_bus.data  = '0;
    dn_bus.ready = 1'b0;
    exp_q.delete();
    hist.delete();
    m_active = 1'b0;
    m_synced = 1'b0;
    @(posedge clock);
    @(negedge clock);
    check_val("rst_out_valid", dn_bus.valid, 1'b0);
    check_val("rst_out_sof", dn_bus.sof, 1'b0);
    check_val("rst_out_data", dn_bus.data, '0);
    check_val("rst_synced", synced, 1'b0);
`ifdef SCRAMBLER_STATE_OUT_EN
    check_val("rst_state_out", state_out, 7'h7F);
`endif
    reset = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, '0, 1'b0, 7'h00, 1'b1, acc);
  endtask

  // Send frame_bits as one frame; optional stall and early abort.
  task automatic send_frame(input bit md, input logic [6:0] sd, input int stall_at,
                            input int stall_len, input int abort_at);
    int                nb;
    int                stalled;
    int                guard;
    bit                acc;
    bit                rdy;
    logic [DATA_W-1:0] d;
    nb = (frame_bits.size() + DATA_W - 1) / DATA_W;
    for (int b = 0; b < nb; b++) begin
      if (b == abort_at) return;
      d = '0;
      for (int i = 0; i < DATA_W; i++)
        if (b*DATA_W + i < frame_bits.size()) d[i] = frame_bits[b*DATA_W + i];
      stalled = 0;
      guard   = 0;
      do begin
        rdy = !(b == stall_at && stalled < stall_len);
        if (!rdy) stalled++;
        cycle(1'b1, b == 0, d, md, sd, rdy, acc);
        guard++;
      end while (!acc && guard < 20);
      if (!acc) check_val("accept_timeout", 32'd0, 32'd1);
    end
  endtask

  function automatic logic [7:0] cap_byte(input int k);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) r[i] = cap_bits[8*k + i];
    return r;
  endfunction

  initial begin
    logic [15:0]       first16;
    logic [7:0]        bytes[4];
    int                bad;
    bit                acc;
    logic [DATA_W-1:0] rd;
    bytes[0] = 8'h00; bytes[1] = 8'h00; bytes[2] = 8'hA5; bytes[3] = 8'h3C;

    do_reset();

    // Test 1: all-ones seed, zero data -> 802.11 sequence, period 127
    frame_bits.delete();
    for (int i = 0; i < 256; i++) frame_bits.push_back(1'b0);
    cap_bits.delete();
    cap_on = 1'b1;
    send_frame(1'b0, 7'h7F, -1, 0, -1);
    idle(2);
    for (int i = 0; i < 16; i++) first16[i] = cap_bits[i];
    check_val("t1_first16", first16, 16'h4F70);
    bad = 0;
    for (int n = 127; n < 256; n++) if (cap_bits[n] != cap_bits[n-127]) bad++;
    check_val("t1_period127", bad, 0);

    // Test 2: TX with seed 5D, then loop the scrambled bits through RX
    frame_bits.delete();
    for (int k = 0; k < 4; k++) for (int i = 0; i < 8; i++) frame_bits.push_back(bytes[k][i]);
    cap_bits.delete();
    send_frame(1'b0, 7'h5D, -1, 0, -1);
    idle(2);
    tx_bits.delete();
    for (int i = 0; i < 32; i++) tx_bits.push_back(cap_bits[i]);
    frame_bits = tx_bits;
    cap_bits.delete();
    send_frame(1'b1, 7'h00, -1, 0, -1);
    idle(2);
    for (int k = 0; k < 4; k++) check_val("t2_rx_byte", cap_byte(k), bytes[k]);
    cap_on = 1'b0;

    // Test 3: downstream stall mid-frame
    frame_bits.delete();
    for (int i = 0; i < 20*DATA_W; i++) frame_bits.push_back(1'($urandom));
    send_frame(1'b0, 7'($urandom), 8, 5, -1);
    idle(2);

    // Test 4: reset mid-frame, then a clean frame
    frame_bits.delete();
    for (int i = 0; i < 10*DATA_W; i++) frame_bits.push_back(1'($urandom));
    send_frame(1'b0, 7'h33, -1, 0, 5);
    do_reset();
    send_frame(1'b0, 7'h33, -1, 0, -1);
    idle(2);

    // Test 5: out-of-frame beats dropped, then sof restart mid-frame with new seed
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, DATA_W'($urandom), 1'b0, 7'h00, 1'b1, acc);
    for (int b = 0; b < 6; b++) begin
      rd = DATA_W'($urandom);
      cycle(1'b1, (b == 0) || (b == 3), rd, 1'b0, (b < 3) ? 7'h2A : 7'h11, 1'b1, acc);
    end
    idle(2);

    // Randomized traffic: random modes, seeds (including 0), sof, valid, ready, resets
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 499) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, DATA_W'($urandom),
              1'($urandom), ($urandom_range(0, 7) == 0) ? 7'h00 : 7'($urandom),
              $urandom_range(0, 3) != 0, acc);
      end
    end
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
